// File: rtl/vme_pkg.sv
// vme_pkg: shared constants, field positions and FSM
// encoding for the DMB VME slave cycle decoder.
package vme_pkg;

  localparam logic [5:0] AM_A24_USER = 6'h39;
  localparam logic [5:0] AM_A24_SUPV = 6'h3D;

  localparam int SLOT_HI = 23;
  localparam int SLOT_LO = 19;
  localparam int DEV_HI  = 15;
  localparam int DEV_LO  = 12;
  localparam int CMD_HI  = 11;
  localparam int CMD_LO  = 2;

  localparam int TO_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_STRB,
    ST_ACK,
    ST_RELEASE
  } vme_state_t;

  function automatic logic am_ok(
    input logic [5:0] am
  );
    return (am == AM_A24_USER) ||
           (am == AM_A24_SUPV);
  endfunction

endpackage

// File: rtl/vme_sync.sv
// vme_sync: STAGES-deep synchroniser for one
// asynchronous VME control line.
module vme_sync
  import vme_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic FASTCLK,
  input  logic RST_B,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // shift the raw line through the flop chain
  always_ff @(posedge FASTCLK) begin
    if (!RST_B) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/vme_cycle_decode.sv
// vme_cycle_decode: VME A24 slave cycle decoder.
// Optional bus-error timeout: VME_BERR_TIMEOUT_EN.
module vme_cycle_decode #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255,
  parameter int NDEV        = 16
) (
  input  logic            FASTCLK,
  input  logic            RST_B,
  input  logic            AS_B,
  input  logic            DS0_B,
  input  logic            DS1_B,
  input  logic            VME_WRITE_B,
  input  logic            LWORD_B,
  input  logic            IACK_B,
  input  logic [5:0]      AM,
  input  logic [23:1]     ADR,
  input  logic [4:0]      GA,
  input  logic            DTACK_IN_B,
  output logic            STROBE,
  output logic            WRITE_B,
  output logic [NDEV-1:0] DEVICE,
  output logic [9:0]      COMMAND,
  output logic            BERR_B,
  output logic            CYC_ACTIVE
);

  import vme_pkg::*;

  localparam int FW = $clog2(SYNC_STAGES + 1);

  if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1 ||
      TIMEOUT_CYC > 1023) begin : g_bad_param
    $error("vme_cycle_decode: bad parameter");
  end

  logic as_s;
  logic ds0_s;
  logic ds1_s;
  logic dt_s;
  logic ds_s;

  vme_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_as (
    .FASTCLK (FASTCLK),
    .RST_B   (RST_B),
    .d       (AS_B),
    .q       (as_s)
  );

  vme_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_ds0 (
    .FASTCLK (FASTCLK),
    .RST_B   (RST_B),
    .d       (DS0_B),
    .q       (ds0_s)
  );

  vme_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_ds1 (
    .FASTCLK (FASTCLK),
    .RST_B   (RST_B),
    .d       (DS1_B),
    .q       (ds1_s)
  );

  vme_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_sync_dt (
    .FASTCLK (FASTCLK),
    .RST_B   (RST_B),
    .d       (DTACK_IN_B),
    .q       (dt_s)
  );

  assign ds_s = ds0_s & ds1_s;

  logic match;
  assign match = (ADR[SLOT_HI:SLOT_LO] == GA) &&
                 am_ok(AM) && IACK_B && LWORD_B;

  logic unused_adr;
  assign unused_adr = ^{ADR[18:16], ADR[1]};

  function automatic logic [NDEV-1:0] dev_onehot(
    input logic [3:0] idx
  );
    logic [NDEV-1:0] v;
    v = '0;
    if (int'(idx) < NDEV) begin
      v = NDEV'(1) << idx;
    end
    return v;
  endfunction

  vme_state_t    state;
  logic [FW-1:0] flush_cnt;
  logic          flushed;
  logic          armed;
  logic [3:0]    dev_q;
  logic [9:0]    cmd_q;
  logic          wr_q;

  // synchroniser outputs are stale until flushed
  assign flushed = (flush_cnt == FW'(SYNC_STAGES));

`ifdef VME_BERR_TIMEOUT_EN
  logic [TO_W-1:0] cnt;
  logic            berr_q;
  assign BERR_B = berr_q;
`else
  assign BERR_B = 1'b1;
`endif

  // cycle FSM with registered bundle outputs
  always_ff @(posedge FASTCLK) begin
    if (!RST_B) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      armed      <= 1'b0;
      dev_q      <= '0;
      cmd_q      <= '0;
      wr_q       <= 1'b1;
      STROBE     <= 1'b0;
      DEVICE     <= '0;
      COMMAND    <= '0;
      WRITE_B    <= 1'b1;
      CYC_ACTIVE <= 1'b0;
`ifdef VME_BERR_TIMEOUT_EN
      cnt        <= '0;
      berr_q     <= 1'b1;
`endif
    end else begin
      if (!flushed) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (flushed && as_s) begin
            armed <= 1'b1;
          end
          if (armed && !as_s && !ds_s) begin
            armed <= 1'b0;
            if (match) begin
              dev_q      <= ADR[DEV_HI:DEV_LO];
              cmd_q      <= ADR[CMD_HI:CMD_LO];
              wr_q       <= VME_WRITE_B;
              CYC_ACTIVE <= 1'b1;
              state      <= ST_DECODE;
            end else begin
              state <= ST_RELEASE;
            end
          end
        end
        ST_DECODE: begin
          COMMAND <= cmd_q;
          WRITE_B <= wr_q;
          DEVICE  <= dev_onehot(dev_q);
          STROBE  <= 1'b1;
`ifdef VME_BERR_TIMEOUT_EN
          cnt     <= '0;
`endif
          state   <= ST_STRB;
        end
        ST_STRB: begin
`ifdef VME_BERR_TIMEOUT_EN
          cnt <= cnt + 1'b1;
`endif
          if (ds_s) begin
            STROBE <= 1'b0;
            DEVICE <= '0;
            state  <= ST_RELEASE;
          end else if (!dt_s) begin
            state <= ST_ACK;
          end
`ifdef VME_BERR_TIMEOUT_EN
          else if (cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            berr_q <= 1'b0;
            STROBE <= 1'b0;
            DEVICE <= '0;
            state  <= ST_RELEASE;
          end
`endif
        end
        ST_ACK: begin
          if (ds_s) begin
            STROBE <= 1'b0;
            DEVICE <= '0;
            state  <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (as_s && ds_s) begin
            CYC_ACTIVE <= 1'b0;
            armed      <= 1'b1;
`ifdef VME_BERR_TIMEOUT_EN
            berr_q     <= 1'b1;
`endif
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vme_cycle_decode.sv
// tb_vme_cycle_decode: table + random vectors and
// hand sequences for the VME cycle decoder.
module tb_vme_cycle_decode;

  localparam int SYNC = 2;
  localparam int TMO  = 8;
  localparam int NDEV = 16;
  localparam int LAT  = SYNC + 2;

  logic        FASTCLK = 1'b0;
  logic        RST_B = 1'b0;
  logic        AS_B = 1'b1;
  logic        DS0_B = 1'b1;
  logic        DS1_B = 1'b1;
  logic        VME_WRITE_B = 1'b1;
  logic        LWORD_B = 1'b1;
  logic        IACK_B = 1'b1;
  logic [5:0]  AM = '0;
  logic [23:1] ADR = '0;
  logic [4:0]  GA = '0;
  logic        DTACK_IN_B = 1'b1;
  logic        STROBE;
  logic        WRITE_B;
  logic [15:0] DEVICE;
  logic [9:0]  COMMAND;
  logic        BERR_B;
  logic        CYC_ACTIVE;

  vme_cycle_decode #(
    .SYNC_STAGES (SYNC),
    .TIMEOUT_CYC (TMO),
    .NDEV        (NDEV)
  ) dut (
    .FASTCLK     (FASTCLK),
    .RST_B       (RST_B),
    .AS_B        (AS_B),
    .DS0_B       (DS0_B),
    .DS1_B       (DS1_B),
    .VME_WRITE_B (VME_WRITE_B),
    .LWORD_B     (LWORD_B),
    .IACK_B      (IACK_B),
    .AM          (AM),
    .ADR         (ADR),
    .GA          (GA),
    .DTACK_IN_B  (DTACK_IN_B),
    .STROBE      (STROBE),
    .WRITE_B     (WRITE_B),
    .DEVICE      (DEVICE),
    .COMMAND     (COMMAND),
    .BERR_B      (BERR_B),
    .CYC_ACTIVE  (CYC_ACTIVE)
  );

  always #5 FASTCLK = ~FASTCLK;

  typedef struct {
    logic [4:0]  ga;
    logic [5:0]  am;
    logic [23:1] adr;
    logic        lword_b;
    logic        iack_b;
    logic        wr_b;
    logic        exp_stb;
    logic [15:0] exp_dev;
    logic [9:0]  exp_cmd;
  } vec_t;

  vec_t tbl[$];

  int   checks = 0;
  int   bad = 0;
  int   inv_bad = 0;
  int   berr_bad = 0;
  bit   berr_ok = 0;
  bit   stb_any = 0;
  bit   cyc_any = 0;
  logic [9:0] last_cmd = '0;
  logic       last_wr = 1'b1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge FASTCLK);
    #1;
    if (STROBE === 1'b1) stb_any = 1;
    if (CYC_ACTIVE === 1'b1) cyc_any = 1;
    if (STROBE === 1'b0 && DEVICE !== '0)
      inv_bad++;
    if (BERR_B === 1'b0 && !berr_ok)
      berr_bad++;
  endtask

  function automatic logic model_match(input vec_t v);
    return (v.adr[23:19] == v.ga) &&
           (v.am == 6'h39 || v.am == 6'h3D) &&
           v.iack_b && v.lword_b;
  endfunction

  function automatic logic [15:0] model_dev(input vec_t v);
    int idx;
    if (!model_match(v)) return 16'h0;
    idx = int'(v.adr[15:12]);
    if (idx >= NDEV) return 16'h0;
    return 16'(1) << idx;
  endfunction

  function automatic vec_t mk(input logic [4:0] ga,
                              input logic [5:0] am,
                              input logic [23:1] adr,
                              input logic lw,
                              input logic ia,
                              input logic wr,
                              input logic stb,
                              input logic [15:0] dev,
                              input logic [9:0] cmd);
    vec_t v;
    v.ga = ga; v.am = am; v.adr = adr;
    v.lword_b = lw; v.iack_b = ia; v.wr_b = wr;
    v.exp_stb = stb; v.exp_dev = dev;
    v.exp_cmd = cmd;
    return v;
  endfunction

  task automatic start(input vec_t v, input int sel);
    GA = v.ga; AM = v.am; ADR = v.adr;
    LWORD_B = v.lword_b; IACK_B = v.iack_b;
    VME_WRITE_B = v.wr_b;
    AS_B = 1'b0;
    DS0_B = (sel == 2);
    DS1_B = (sel == 1);
  endtask

  task automatic wait_strobe(output int k,
                             output bit seen);
    seen = 0;
    k = 0;
    while (k < 12 && !seen) begin
      tick();
      k++;
      if (STROBE === 1'b1) seen = 1;
    end
  endtask

  task automatic wait_stb_low(input string name);
    int n;
    n = 0;
    while (STROBE !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk(name, STROBE, 1'b0);
  endtask

  task automatic close_bus(input string name);
    int n;
    AS_B = 1'b1; DS0_B = 1'b1; DS1_B = 1'b1;
    DTACK_IN_B = 1'b1;
    n = 0;
    while (CYC_ACTIVE !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    chk(name, CYC_ACTIVE, 1'b0);
    repeat (3) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_strobe"}, STROBE, 1'b0);
    chk({tag, "_device"}, DEVICE, 16'h0);
    chk({tag, "_command"}, COMMAND, 10'h0);
    chk({tag, "_write_b"}, WRITE_B, 1'b1);
    chk({tag, "_berr_b"}, BERR_B, 1'b1);
    chk({tag, "_cyc"}, CYC_ACTIVE, 1'b0);
  endtask

  task automatic run_cycle(input vec_t v, input int sel);
    int  k;
    bit  seen;
    stb_any = 0;
    cyc_any = 0;
    start(v, sel);
    wait_strobe(k, seen);
    chk("strobe_seen", seen, v.exp_stb);
    if (seen && v.exp_stb) begin
      chk("latency", k, LAT);
      chk("device", DEVICE, v.exp_dev);
      chk("command", COMMAND, v.exp_cmd);
      chk("write_b", WRITE_B, v.wr_b);
      chk("cyc_active", CYC_ACTIVE, 1'b1);
      tick();
      DTACK_IN_B = 1'b0;
      repeat (4) tick();
      chk("strobe_hold_ack", STROBE, 1'b1);
      DS0_B = 1'b1; DS1_B = 1'b1;
      wait_stb_low("strobe_drop_ds");
      chk("device_drop", DEVICE, 16'h0);
      chk("cyc_until_as", CYC_ACTIVE, 1'b1);
      close_bus("cyc_clear");
      last_cmd = v.exp_cmd;
      last_wr  = v.wr_b;
    end else begin
      repeat (6) tick();
      chk("reject_no_strobe", stb_any, 1'b0);
      chk("reject_no_cyc", cyc_any, 1'b0);
      close_bus("reject_cyc_clear");
    end
    chk("command_hold", COMMAND, last_cmd);
    chk("write_hold", WRITE_B, last_wr);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   k;
    int   n;
    bit   seen;

    tbl.push_back(mk(5'd5, 6'h39,
      {5'd5, 3'd0, 4'd7, 10'd0, 1'b0},
      1, 1, 1, 1, 16'h0080, 10'h000));
    tbl.push_back(mk(5'd5, 6'h39,
      {5'd6, 3'd0, 4'd7, 10'd0, 1'b0},
      1, 1, 1, 0, 16'h0, 10'h0));
    tbl.push_back(mk(5'h1F, 6'h39,
      {5'h1F, 3'd0, 4'd0, 10'h155, 1'b0},
      1, 1, 1, 1, 16'h0001, 10'h155));
    tbl.push_back(mk(5'd5, 6'h09,
      {5'd5, 3'd0, 4'd2, 10'd4, 1'b0},
      1, 1, 1, 0, 16'h0, 10'h0));
    tbl.push_back(mk(5'd5, 6'h39,
      {5'd5, 3'd0, 4'd2, 10'd4, 1'b0},
      0, 1, 1, 0, 16'h0, 10'h0));
    tbl.push_back(mk(5'd5, 6'h3D,
      {5'd5, 3'd0, 4'd2, 10'd4, 1'b0},
      1, 0, 1, 0, 16'h0, 10'h0));
    tbl.push_back(mk(5'd5, 6'h3D,
      {5'd5, 3'b101, 4'hF, 10'h3FF, 1'b1},
      1, 1, 0, 1, 16'h8000, 10'h3FF));

    for (int i = 0; i < 30; i++) begin
      int r;
      v.ga = 5'($urandom);
      v.adr = 23'($urandom);
      if ($urandom_range(0, 2) != 0)
        v.adr[23:19] = v.ga;
      r = $urandom_range(0, 3);
      v.am = (r == 0) ? 6'h39 :
             (r == 1) ? 6'h3D :
             (r == 2) ? 6'h09 : 6'($urandom);
      v.lword_b = ($urandom_range(0, 5) != 0);
      v.iack_b  = ($urandom_range(0, 5) != 0);
      v.wr_b    = 1'($urandom);
      v.exp_stb = model_match(v);
      v.exp_dev = model_dev(v);
      v.exp_cmd = v.adr[11:2];
      tbl.push_back(v);
    end

    RST_B = 1'b0;
    repeat (3) tick();
    chk_reset("reset");
    RST_B = 1'b1;
    repeat (6) tick();

    foreach (tbl[i]) begin
      run_cycle(tbl[i], (i % 3) + 1);
    end

    // no DTACK: timeout or indefinite strobe
    v = tbl[0];
    start(v, 3);
    wait_strobe(k, seen);
    chk("to_strobe_seen", seen, 1'b1);
`ifdef VME_BERR_TIMEOUT_EN
    n = 0;
    while (STROBE === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_strobe_cycles", n, TMO);
    chk("to_berr_low", BERR_B, 1'b0);
    chk("to_device_zero", DEVICE, 16'h0);
    berr_ok = 1;
    repeat (3) tick();
    chk("to_berr_held", BERR_B, 1'b0);
    AS_B = 1'b1; DS0_B = 1'b1; DS1_B = 1'b1;
    n = 0;
    while (BERR_B !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("to_berr_release", BERR_B, 1'b1);
    berr_ok = 0;
    close_bus("to_cyc_clear");
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (STROBE !== 1'b1) n++;
    end
    chk("nto_strobe_drops", n, 0);
    chk("nto_berr_b", BERR_B, 1'b1);
    DS0_B = 1'b1; DS1_B = 1'b1;
    wait_stb_low("nto_strobe_drop");
    close_bus("nto_cyc_clear");
`endif

    // DTACK lands on the timeout edge
    start(tbl[2], 1);
    wait_strobe(k, seen);
    chk("co_strobe_seen", seen, 1'b1);
    repeat (5) tick();
    DTACK_IN_B = 1'b0;
    repeat (6) tick();
    chk("co_strobe_ack", STROBE, 1'b1);
    chk("co_berr_b", BERR_B, 1'b1);
    DS0_B = 1'b1; DS1_B = 1'b1;
    wait_stb_low("co_strobe_drop");
    close_bus("co_cyc_clear");
    last_cmd = tbl[2].exp_cmd;
    last_wr  = tbl[2].wr_b;

    // reset while in STRB with AS held low
    start(tbl[6], 3);
    wait_strobe(k, seen);
    chk("rm_strobe_seen", seen, 1'b1);
    repeat (2) tick();
    RST_B = 1'b0;
    tick();
    chk_reset("rm");
    RST_B = 1'b1;
    stb_any = 0;
    cyc_any = 0;
    repeat (12) tick();
    chk("rm_no_strobe", stb_any, 1'b0);
    chk("rm_no_cyc", cyc_any, 1'b0);
    AS_B = 1'b1; DS0_B = 1'b1; DS1_B = 1'b1;
    repeat (5) tick();
    last_cmd = 10'h0;
    last_wr  = 1'b1;
    run_cycle(tbl[0], 3);
    run_cycle(tbl[6], 2);

    chk("device_only_with_strobe", inv_bad, 0);
    chk("berr_unexpected", berr_bad, 0);
    $display("test done: total=%0d bad=%0d",
             checks, bad);
    $finish;
  end

endmodule
